vector_recorder: RTL and testbench
==================================

VECTOR_RECORDER -- requirements
Module: vector_recorder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning vector buffer entries (power of two, at least 2).
REQ-002 SHALL have parameter VW, default 14, meaning vector width; field order is xxxx_yyyy_i_o_ssss, bit 13 down to bit 0.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse that arms capture (IDLE only).
REQ-006 SHALL have port stop  input  1  ends capture early (CAPTURE only).
REQ-007 SHALL have port cap_valid  input  1  DUT port values are valid this cycle.
REQ-008 SHALL have ports x, y  input  4 each  DUT operand inputs.
REQ-009 SHALL have ports ci, co  input  1 each  DUT carry in and carry out.
REQ-010 SHALL have port s  input  4  DUT sum output.
REQ-011 SHALL have port out_valid  output  1  out_data holds a drained vector.
REQ-012 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-013 SHALL have port out_data  output  VW  drained vector {x,y,ci,co,s}.
REQ-014 SHALL have port count  output  clog2(DEPTH)+1  number of stored, undrained vectors.
REQ-015 SHALL have port busy  output  1  high in CAPTURE or DRAIN.
REQ-016 SHALL have port done  output  1  one-cycle pulse when the last vector is accepted.
REQ-017 SHALL have port err_cnt  output  16  mismatch count (see Configuration).

Function
REQ-018 SHALL implement the FSM states IDLE, CAPTURE, and DRAIN.
REQ-019 IDLE->CAPTURE SHALL occur on start; start outside IDLE SHALL be ignored.
REQ-020 In CAPTURE, when cap_valid=1, the block SHALL write {x,y,ci,co,s} at the write pointer and increment the pointer and count in the same clock edge.
REQ-021 CAPTURE->DRAIN SHALL occur on the edge where the write makes count=DEPTH, or on stop; stop and cap_valid together SHALL still store that vector.
REQ-022 CAPTURE->DRAIN with count=0 SHALL go directly to IDLE, pulsing done.
REQ-023 In DRAIN, out_valid SHALL be 1 and out_data SHALL be the entry at the read pointer, registered, with no combinational path from out_ready.
REQ-024 A transfer SHALL occur when out_valid and out_ready are both high; the read pointer SHALL advance and count SHALL decrement.
REQ-025 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 The transfer that makes count 0 SHALL return the FSM to IDLE and pulse done on the following cycle; out_valid SHALL drop on that same edge.
REQ-027 Vectors SHALL drain in capture order (FIFO); both pointers SHALL wrap modulo DEPTH.
REQ-028 Writes in DRAIN or IDLE SHALL be ignored; cap_valid while full is impossible by REQ-021.
REQ-029 busy SHALL be 1 exactly when the state is CAPTURE or DRAIN.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately force state IDLE, pointers 0, count 0, out_valid 0, out_data 0, done 0, busy 0, err_cnt 0, even mid-capture or mid-drain.
REQ-031 Buffer contents SHALL NOT require reset; stale entries SHALL be unreachable after reset.
REQ-032 The first capture SHALL be accepted no earlier than the first posedge after rst_n deasserts.

Configuration
REQ-033 With macro VREC_CHECK_EN defined, each captured vector SHALL be checked against {co,s} = x+y+ci, and err_cnt SHALL increment on a mismatch, saturating at 16'hFFFF and clearing on start.
REQ-034 Without VREC_CHECK_EN, the checker SHALL be absent and err_cnt SHALL be constant 0.

Verification
REQ-035 Capture x=3,y=4,ci=1,co=0,s=8, stop, and hold out_ready=1 -> one transfer with out_data=14'b0011_0100_1_0_1000, then a done pulse and busy=0.
REQ-036 Capture 16 vectors without stop -> the FSM enters DRAIN when count=16, and 16 ordered transfers follow.
REQ-037 Hold out_ready=0 for 5 cycles during DRAIN -> out_valid stays 1 with out_data unchanged, and count is unchanged.
REQ-038 Drive rst_n low mid-drain with count=7 -> all outputs go to their reset values before the next clk edge; a new start captures from entry 0.
REQ-039 With VREC_CHECK_EN defined, capture 15+15+1 reporting {co,s}=5'b0_0000 and then 15+15+1 reporting 5'b1_1111 -> err_cnt=1.
REQ-040 Pulse start then stop with no cap_valid -> a done pulse follows, out_valid is never asserted, and the FSM is in IDLE.

Source files
------------

// File: rtl/vector_recorder.sv
// vector_recorder: records {x,y,ci,co,s} port vectors of an adder under test into a
// small FIFO buffer while capturing, then streams them out over a valid/ready port.
// Optional macro VREC_CHECK_EN adds an on-the-fly adder checker driving err_cnt;
// without it err_cnt is tied to zero.
module vector_recorder #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned VW    = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   cap_valid,
    input  logic [3:0]             x,
    input  logic [3:0]             y,
    input  logic                   ci,
    input  logic                   co,
    input  logic [3:0]             s,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [VW-1:0]          out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            err_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StCapture, StDrain} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            out_valid_q, out_valid_d;
    logic [VW-1:0]   out_data_q, out_data_d;
    logic            done_q, done_d;
    logic [VW-1:0]   mem_q [DEPTH];

    logic [VW-1:0]   wdata;
    logic            wr_en, xfer, cap_full, cap_end, cap_empty_end, last_xfer;

    assign wdata = VW'({x, y, ci, co, s});

    // Decode the events that drive both the FSM and the datapath
    always_comb begin
        wr_en         = (state_q == StCapture) && cap_valid;
        xfer          = out_valid_q && out_ready;
        cap_full      = wr_en && (count_q == CW'(DEPTH - 1));
        cap_end       = (state_q == StCapture) && (stop || cap_full);
        cap_empty_end = cap_end && !wr_en && (count_q == '0);
        last_xfer     = xfer && (count_q == CW'(1));
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StCapture;
            StCapture: if (cap_end) state_d = cap_empty_end ? StIdle : StDrain;
            StDrain:   if (last_xfer) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != StIdle);
    end

    // Datapath next-state: pointers, occupancy, registered output slot, done pulse
    always_comb begin
        wr_ptr_d    = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = xfer ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q + CW'(wr_en) - CW'(xfer);
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = cap_empty_end || last_xfer;
        if (cap_end && !cap_empty_end) begin
            out_valid_d = 1'b1;
            // The head entry may be the one being written on this very edge
            out_data_d  = (wr_en && (wr_ptr_q == rd_ptr_q)) ? wdata : mem_q[rd_ptr_q];
        end else if (last_xfer) begin
            out_valid_d = 1'b0;
        end else if (xfer) begin
            out_data_d  = mem_q[rd_ptr_q + AW'(1)];
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    // Vector storage; no reset needed since pointers gate every access
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign count     = count_q;
    assign done      = done_q;

`ifdef VREC_CHECK_EN
    logic [4:0]  sum;
    logic        mismatch;
    logic [15:0] err_q, err_d;

    // Adder checker: saturating mismatch counter, cleared by an accepted start
    always_comb begin
        sum      = 5'(x) + 5'(y) + 5'(ci);
        mismatch = wr_en && ({co, s} != sum);
        err_d    = err_q;
        if ((state_q == StIdle) && start) err_d = '0;
        else if (mismatch && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
    end

    // Checker count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= '0;
        else        err_q <= err_d;
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_vector_recorder.sv
// Directed bench for vector_recorder with a queue scoreboard of expected drained vectors.
module tb_vector_recorder;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned VW    = 14;
`ifdef VREC_CHECK_EN
    localparam int unsigned EXP_ERR = 1;
`else
    localparam int unsigned EXP_ERR = 0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic                   stop = 1'b0;
    logic                   cap_valid = 1'b0;
    logic [3:0]             x = '0;
    logic [3:0]             y = '0;
    logic                   ci = 1'b0;
    logic                   co = 1'b0;
    logic [3:0]             s = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [VW-1:0]          out_data;
    logic [$clog2(DEPTH):0] count;
    logic                   busy;
    logic                   done;
    logic [15:0]            err_cnt;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [13:0] exp_q [$];

    vector_recorder #(.DEPTH(DEPTH), .VW(VW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cap_valid(cap_valid),
        .x(x), .y(y), .ci(ci), .co(co), .s(s),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .busy(busy), .done(done), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // Drive one capture beat and record what should later drain
    task automatic cap(input logic [3:0] xx, input logic [3:0] yy, input logic cc,
                       input logic oo, input logic [3:0] ss, input logic st);
        x = xx; y = yy; ci = cc; co = oo; s = ss;
        cap_valid = 1'b1;
        stop = st;
        exp_q.push_back({xx, yy, cc, oo, ss});
        tick;
        cap_valid = 1'b0;
        stop = 1'b0;
    endtask

    // Capture with a correct adder result
    task automatic cap_good(input logic [3:0] xx, input logic [3:0] yy, input logic cc,
                            input logic st);
        logic [4:0] sm;
        sm = 5'(xx) + 5'(yy) + 5'(cc);
        cap(xx, yy, cc, sm[4], sm[3:0], st);
    endtask

    // Accept everything with out_ready=1 and check order, count, then the done pulse
    task automatic drain_all(input string tag);
        int          budget;
        logic [13:0] e;
        budget = 0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && budget < 200) begin
            if (out_valid === 1'b1) begin
                check({tag, "_count"}, 32'(count), 32'(exp_q.size()));
                e = exp_q.pop_front();
                check({tag, "_data"}, 32'(out_data), 32'(e));
            end
            tick;
            budget++;
        end
        if (exp_q.size() > 0) begin
            check({tag, "_timeout_left"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_valid_low"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_count0"}, 32'(count), 32'd0);
        out_ready = 1'b0;
        tick;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        // Reset state
        tick;
        tick;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        #3 rst_n = 1'b1;
        tick;

        // Single vector, then stop
        pulse_start;
        check("t1_busy", 32'(busy), 32'd1);
        cap(4'd3, 4'd4, 1'b1, 1'b0, 4'd8, 1'b0);
        check("t1_count", 32'(count), 32'd1);
        check("t1_novalid", 32'(out_valid), 32'd0);
        stop = 1'b1;
        tick;
        stop = 1'b0;
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_literal", 32'(out_data), 32'h0D28);
        drain_all("t1");

        // Fill to DEPTH without stop
        pulse_start;
        for (int i = 0; i < DEPTH; i++) cap_good(4'(i), 4'(15 - i), 1'(i), 1'b0);
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_full", 32'(count), 32'(DEPTH));
        check("t2_busy", 32'(busy), 32'd1);
        drain_all("t2");

        // Back-pressure hold; writes and start during DRAIN ignored
        pulse_start;
        cap_good(4'd1, 4'd2, 1'b0, 1'b0);
        cap_good(4'd7, 4'd9, 1'b1, 1'b0);
        cap_good(4'd12, 4'd5, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_data", 32'(out_data), 32'(exp_q[0]));
            check("t3_hold_count", 32'(count), 32'd3);
            x = 4'd9; y = 4'd9; cap_valid = 1'b1;
            start = (i == 2);
            tick;
        end
        cap_valid = 1'b0;
        start = 1'b0;
        check("t3_after_data", 32'(out_data), 32'(exp_q[0]));
        drain_all("t3");

        // Checker: one bad sum, one good sum
        pulse_start;
        cap(4'd15, 4'd15, 1'b1, 1'b0, 4'b0000, 1'b0);
        cap(4'd15, 4'd15, 1'b1, 1'b1, 4'b1111, 1'b1);
        check("t4_err", 32'(err_cnt), 32'(EXP_ERR));
        drain_all("t4");
        check("t4_err_hold", 32'(err_cnt), 32'(EXP_ERR));

        // Start then stop with nothing captured; start clears err_cnt
        pulse_start;
        check("t5_err_clear", 32'(err_cnt), 32'd0);
        stop = 1'b1;
        tick;
        stop = 1'b0;
        check("t5_done", 32'(done), 32'd1);
        check("t5_idle", 32'(busy), 32'd0);
        check("t5_novalid", 32'(out_valid), 32'd0);
        tick;
        check("t5_done_pulse", 32'(done), 32'd0);
        check("t5_still_novalid", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-drain with count=7
        pulse_start;
        for (int i = 0; i < 8; i++) cap_good(4'(i + 2), 4'(i), 1'b1, 1'(i == 7));
        out_ready = 1'b1;
        begin
            logic [13:0] e;
            e = exp_q.pop_front();
            check("t6_first", 32'(out_data), 32'(e));
        end
        tick;
        out_ready = 1'b0;
        check("t6_count7", 32'(count), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_data", 32'(out_data), 32'd0);
        check("t6_rst_count", 32'(count), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        check("t6_rst_err", 32'(err_cnt), 32'd0);
        exp_q.delete();
        tick;
        #3 rst_n = 1'b1;
        tick;
        pulse_start;
        cap_good(4'd10, 4'd11, 1'b0, 1'b0);
        cap_good(4'd13, 4'd1, 1'b1, 1'b1);
        drain_all("t6_post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
